// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared widths and bit positions for the pipelined ball renderer
package draw_pkg;
    localparam int HCW   = 12;
    localparam int VCW   = 11;
    localparam int SQW   = 2 * HCW;
    localparam int DSQ_W = 25;

    localparam int OUT_V = 3;
    localparam int OUT_R = 2;
    localparam int OUT_G = 1;
    localparam int OUT_B = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ball_dist_sq.sv
// rtl/ball_dist_sq.sv - stage 1 for one slot: signed deltas, squared and registered
module ball_dist_sq
    import draw_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int SW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HCW-1:0]    hcounter,
    input  logic [VCW-1:0]    vcounter,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [SW-1:0]     size,
    output logic [SQW-1:0]    dx_sq,
    output logic [SQW-1:0]    dy_sq,
    output logic [2*SW-1:0]   r_sq
);
    localparam int DXW = HCW + 1;
    localparam int DYW = VCW + 1;

    logic [DXW-1:0]  dx, dx_mag;
    logic [DYW-1:0]  dy, dy_mag;
    logic [SQW-1:0]  dx_ext, dy_ext;
    logic [2*SW-1:0] r_ext;
    logic [SQW-1:0]  dx_sq_d, dx_sq_q, dy_sq_d, dy_sq_q;
    logic [2*SW-1:0] r_sq_d, r_sq_q;

    // Full-width signed deltas keep balls near the edges from wrapping around.
    always_comb begin
        dx      = {1'b0, hcounter} - {{(DXW-XW){1'b0}}, x};
        dy      = {1'b0, vcounter} - {{(DYW-YW){1'b0}}, y};
        dx_mag  = dx[DXW-1] ? -dx : dx;
        dy_mag  = dy[DYW-1] ? -dy : dy;
        dx_ext  = {{(SQW-DXW){1'b0}}, dx_mag};
        dy_ext  = {{(SQW-DYW){1'b0}}, dy_mag};
        r_ext   = {{SW{1'b0}}, size};
        dx_sq_d = dx_ext * dx_ext;
        dy_sq_d = dy_ext * dy_ext;
        r_sq_d  = r_ext * r_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_sq_q <= '0;
            dy_sq_q <= '0;
            r_sq_q  <= '0;
        end else begin
            dx_sq_q <= dx_sq_d;
            dy_sq_q <= dy_sq_d;
            r_sq_q  <= r_sq_d;
        end
    end

    assign dx_sq = dx_sq_q;
    assign dy_sq = dy_sq_q;
    assign r_sq  = r_sq_q;
endmodule

// File: rtl/draw_ball_pipe.sv
// rtl/draw_ball_pipe.sv - two-stage multi-ball renderer with per-frame shadow registers
module draw_ball_pipe
    import draw_pkg::*;
#(
    parameter int CNT = 3,
    parameter int XW  = 10,
    parameter int YW  = 10,
    parameter int SW  = 6,
    parameter int LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    de,
    input  logic [HCW-1:0]          hcounter,
    input  logic [VCW-1:0]          vcounter,
    input  logic [CNT*XW-1:0]       xs,
    input  logic [CNT*YW-1:0]       ys,
    input  logic [CNT*SW-1:0]       sizes,
    input  logic [CNT*3-1:0]        colors,
    input  logic [CNT-1:0]          balls,
    output logic [3:0]              out,
    output logic [idx_w(CNT)-1:0]   hit_idx
);
    localparam int IW = idx_w(CNT);

    logic [CNT*XW-1:0] x_sh_d, x_sh_q;
    logic [CNT*YW-1:0] y_sh_d, y_sh_q;
    logic [CNT*SW-1:0] s_sh_d, s_sh_q;
    logic [CNT*3-1:0]  c_sh_d, c_sh_q;
    logic [CNT-1:0]    a_sh_d, a_sh_q;

    logic              de1_d, de1_q;
    logic [CNT-1:0]    act1_d, act1_q;
    logic [CNT*3-1:0]  col1_d, col1_q;
    logic [3:0]        out_d, out_q;
    logic [IW-1:0]     idx_d, idx_q;

    logic [SQW-1:0]    dx_sq [CNT];
    logic [SQW-1:0]    dy_sq [CNT];
    logic [2*SW-1:0]   r_sq  [CNT];
    logic [DSQ_W-1:0]  dsum  [CNT];
    logic [CNT-1:0]    hit;

    for (genvar g = 0; g < CNT; g++) begin : g_slot
        ball_dist_sq #(.XW(XW), .YW(YW), .SW(SW)) u_dist (
            .clk      (clk),
            .rst      (rst),
            .hcounter (hcounter),
            .vcounter (vcounter),
            .x        (x_sh_q[g*XW +: XW]),
            .y        (y_sh_q[g*YW +: YW]),
            .size     (s_sh_q[g*SW +: SW]),
            .dx_sq    (dx_sq[g]),
            .dy_sq    (dy_sq[g]),
            .r_sq     (r_sq[g])
        );
        assign dsum[g] = {1'b0, dx_sq[g]} + {1'b0, dy_sq[g]};
        assign hit[g]  = act1_q[g] & de1_q &
                         (dsum[g] <= {{(DSQ_W-2*SW){1'b0}}, r_sq[g]});
    end

    // Colour and active bit travel with stage 1 so a mid-pipe frame_start cannot mix frames.
    always_comb begin
        x_sh_d = frame_start ? xs     : x_sh_q;
        y_sh_d = frame_start ? ys     : y_sh_q;
        s_sh_d = frame_start ? sizes  : s_sh_q;
        c_sh_d = frame_start ? colors : c_sh_q;
        a_sh_d = frame_start ? balls  : a_sh_q;
        de1_d  = de;
        act1_d = a_sh_q;
        col1_d = c_sh_q;
        out_d  = '0;
        idx_d  = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                out_d = {1'b1, col1_q[i*3 +: 3]};
                idx_d = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh_q <= '0;
            y_sh_q <= '0;
            s_sh_q <= '0;
            c_sh_q <= '0;
            a_sh_q <= '0;
            de1_q  <= 1'b0;
            act1_q <= '0;
            col1_q <= '0;
            out_q  <= '0;
            idx_q  <= '0;
        end else begin
            x_sh_q <= x_sh_d;
            y_sh_q <= y_sh_d;
            s_sh_q <= s_sh_d;
            c_sh_q <= c_sh_d;
            a_sh_q <= a_sh_d;
            de1_q  <= de1_d;
            act1_q <= act1_d;
            col1_q <= col1_d;
            out_q  <= out_d;
            idx_q  <= idx_d;
        end
    end

    assign out     = out_q;
    assign hit_idx = idx_q;
endmodule
